div_iter_core: RTL and testbench

Multi-cycle unsigned restoring divider directly upstream of the divider sign-correction stage. It takes two signed 32-bit operands and captures their sign bits, divides their magnitudes at one quotient bit per cycle, and presents the unsigned quotient magnitude plus both operand signs. The downstream stage reads these and performs the final two's-complement correction. It also flags divide-by-zero for the processor's exception path.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_step.sv | 24 ++
 rtl/div_iter_core.sv | 139 +++++++++++++
 tb/tb_div_iter_core.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
// Used by div_step and div_iter_core; the datapath width is fixed at 32 bits.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } div_state_e;

  typedef logic [4:0] div_count_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [DIV_WIDTH-1:0] div_mag(input logic [DIV_WIDTH-1:0] v);
    return v[DIV_WIDTH-1] ? (~v + DIV_WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,q} left by one,
// then subtract the divisor when it fits and record the quotient bit.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH:0]   rem_i,
  input  logic [DIV_WIDTH-1:0] q_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic [DIV_WIDTH:0]   rem_o,
  output logic [DIV_WIDTH-1:0] q_o
);

  logic [DIV_WIDTH+1:0] trial;
  logic [DIV_WIDTH:0]   diff;
  logic                 ge;

  // rem_i[32] is always zero between steps; keeping it in the compare is free.
  assign trial = {rem_i, q_i[DIV_WIDTH-1]};
  assign ge    = trial >= {2'b00, divisor_i};
  assign diff  = trial[DIV_WIDTH:0] - {1'b0, divisor_i};
  assign rem_o = ge ? diff : trial[DIV_WIDTH:0];
  assign q_o   = {q_i[DIV_WIDTH-2:0], ge};

endmodule

// File: rtl/div_iter_core.sv
// Unsigned restoring divider core: latches signs, divides magnitudes one bit per cycle.
// Optional macro DIV_REMAINDER_EN adds the 'remainder' output port.
//   state | meaning
//   IDLE  | waiting for ctrl_DIV
//   PREP  | form magnitudes, detect divide-by-zero
//   ITER  | 32 restoring steps
//   DONE  | data_resultRDY pulse
module div_iter_core
  import div_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 ctrl_DIV,
  input  logic [DIV_WIDTH-1:0] data_operandA,
  input  logic [DIV_WIDTH-1:0] data_operandB,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic                 dividend_sign,
  output logic                 divisor_sign,
  output logic                 data_resultRDY,
  output logic                 data_exception,
  output logic                 busy
`ifdef DIV_REMAINDER_EN
  ,
  output logic [DIV_WIDTH-1:0] remainder
`endif
);

  div_state_e           state_q, state_d;
  div_count_t           cnt_q, cnt_d;
  logic [DIV_WIDTH:0]   rem_q, rem_d;
  logic [DIV_WIDTH-1:0] q_q, q_d;
  logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
  logic                 sa_q, sa_d;
  logic                 sb_q, sb_d;
  logic                 exc_q, exc_d;

  logic [DIV_WIDTH:0]   step_rem;
  logic [DIV_WIDTH-1:0] step_q;
  logic                 dvs_zero;

  assign dvs_zero = (dvs_q == '0);

  div_step u_step (
    .rem_i     (rem_q),
    .q_i       (q_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ctrl_DIV) state_d = PREP;
      PREP:    state_d = dvs_zero ? DONE : ITER;
      ITER:    if (cnt_q == div_count_t'(DIV_ITERS - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q == PREP) || (state_q == ITER);
    data_resultRDY = (state_q == DONE);
  end

  // Operands are latched raw on start and converted to magnitudes in place during PREP.
  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    q_d   = q_q;
    dvs_d = dvs_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    exc_d = exc_q;
    case (state_q)
      IDLE: begin
        if (ctrl_DIV) begin
          q_d   = data_operandA;
          dvs_d = data_operandB;
          sa_d  = data_operandA[DIV_WIDTH-1];
          sb_d  = data_operandB[DIV_WIDTH-1];
          exc_d = 1'b0;
        end
      end
      PREP: begin
        dvs_d = div_mag(dvs_q);
        rem_d = '0;
        cnt_d = '0;
        if (dvs_zero) begin
          q_d   = '0;
          exc_d = 1'b1;
        end else begin
          q_d = div_mag(q_q);
        end
      end
      ITER: begin
        rem_d = step_rem;
        q_d   = step_q;
        cnt_d = cnt_q + div_count_t'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
      rem_q <= '0;
      q_q   <= '0;
      dvs_q <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      exc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      q_q   <= q_d;
      dvs_q <= dvs_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      exc_q <= exc_d;
    end
  end

  assign quotient       = q_q;
  assign dividend_sign  = sa_q;
  assign divisor_sign   = sb_q;
  assign data_exception = exc_q;
`ifdef DIV_REMAINDER_EN
  assign remainder      = rem_q[DIV_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_div_iter_core.sv
// Self-checking bench for div_iter_core: vector table with a result scoreboard,
// plus directed sequences for ignored starts and resets during a division.
module tb_div_iter_core;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] quotient;
  logic        dividend_sign;
  logic        divisor_sign;
  logic        data_resultRDY;
  logic        data_exception;
  logic        busy;
`ifdef DIV_REMAINDER_EN
  logic [31:0] remainder;
`endif

  div_iter_core dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .quotient       (quotient),
    .dividend_sign  (dividend_sign),
    .divisor_sign   (divisor_sign),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception),
    .busy           (busy)
`ifdef DIV_REMAINDER_EN
    ,
    .remainder      (remainder)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] rem;
    logic        sa;
    logic        sb;
    logic        exc;
    int          lat;
  } vec_t;

  vec_t vecs[12];
  vec_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                              input logic [31:0] rem, input logic sa, input logic sb, input logic exc);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.rem = rem; v.sa = sa; v.sb = sb; v.exc = exc;
    v.lat = exc ? 2 : 34;
    return v;
  endfunction

  // Called at a negedge. inject_at: cycle at which a second start is attempted (0 = none).
  // poke_done: assert ctrl_DIV during the DONE cycle, which must be ignored.
  task automatic run_vec(input vec_t v, input int inject_at, input bit poke_done);
    int   lat;
    int   extra;
    bit   seen;
    vec_t e;
    sbq.push_back(v);
    data_operandA = v.a;
    data_operandB = v.b;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clock);
      lat++;
      ctrl_DIV = 1'b0;
      if (lat == 1) begin
        chk("exc_cleared_on_start", {31'd0, data_exception}, 32'd0);
        data_operandA = $urandom;
        data_operandB = $urandom;
      end
      if (inject_at != 0 && lat == inject_at) begin
        data_operandA = 32'd1000;
        data_operandB = 32'd3;
        ctrl_DIV      = 1'b1;
      end
      if (data_resultRDY) seen = 1'b1;
    end
    e = sbq.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: no data_resultRDY within 100 cycles for A=0x%08h B=0x%08h", e.a, e.b);
    end else begin
      chk("latency", lat, e.lat);
      chk("quotient", quotient, e.q);
      chk("dividend_sign", {31'd0, dividend_sign}, {31'd0, e.sa});
      chk("divisor_sign", {31'd0, divisor_sign}, {31'd0, e.sb});
      chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
`ifdef DIV_REMAINDER_EN
      chk("remainder", remainder, e.rem);
`endif
      if (poke_done) begin
        data_operandA = 32'd55;
        data_operandB = 32'd5;
        ctrl_DIV      = 1'b1;
      end
      @(negedge clock);
      ctrl_DIV = 1'b0;
      chk("rdy_single_pulse", {31'd0, data_resultRDY}, 32'd0);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clock);
        if (data_resultRDY) extra++;
      end
      chk("no_extra_rdy", extra, 0);
      chk("quotient_held", quotient, e.q);
      chk("exception_held", {31'd0, data_exception}, {31'd0, e.exc});
    end
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_cnt;

    vecs[0]  = mk(32'd100,       32'd7,          32'd14,         32'd2, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(32'hFFFFFF9C,  32'd7,          32'd14,         32'd2, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(32'd12345,     32'd0,          32'd0,          32'd0, 1'b0, 1'b0, 1'b1);
    vecs[3]  = mk(32'h80000000,  32'hFFFFFFFF,   32'h80000000,   32'd0, 1'b1, 1'b1, 1'b0);
    vecs[4]  = mk(32'd7,         32'd100,        32'd0,          32'd7, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(32'h7FFFFFFF,  32'd2,          32'h3FFFFFFF,   32'd1, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mk(32'h80000000,  32'h80000000,   32'd1,          32'd0, 1'b1, 1'b1, 1'b0);
    vecs[7]  = mk(32'hFFFFFFF9,  32'hFFFFFFFE,   32'd3,          32'd1, 1'b1, 1'b1, 1'b0);
    vecs[8]  = mk(32'd0,         32'd0,          32'd0,          32'd0, 1'b0, 1'b0, 1'b1);
    vecs[9]  = mk(32'hFFFFFFFF,  32'd1,          32'd1,          32'd0, 1'b1, 1'b0, 1'b0);
    vecs[10] = mk(32'hDEADBEEF,  32'h00000010,   32'h02152411,   32'd1, 1'b1, 1'b0, 1'b0);
    vecs[11] = mk(32'h7FFFFFFF,  32'h7FFFFFFF,   32'd1,          32'd0, 1'b0, 1'b0, 1'b0);

    reset_n       = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_signs", {30'd0, dividend_sign, divisor_sign}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset_exception", {31'd0, data_exception}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
`ifdef DIV_REMAINDER_EN
    chk("reset_remainder", remainder, 32'd0);
`endif
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], 0, (i == 4));

    // A second start at cycle 5 is ignored and never queued.
    run_vec(vecs[0], 5, 1'b0);

    // Reset at cycle 10 aborts the division with no result pulse.
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_signs", {30'd0, dividend_sign, divisor_sign}, 32'd0);
    rdy_cnt = 0;
    for (int i = 11; i <= 40; i++) begin
      if (data_resultRDY || busy) rdy_cnt++;
      @(negedge clock);
    end
    chk("abort_no_rdy", rdy_cnt, 0);
    run_vec(vecs[0], 0, 1'b0);

    // Reset and start in the same cycle: reset wins and the start is lost.
    reset_n       = 1'b0;
    ctrl_DIV      = 1'b1;
    data_operandA = 32'hFFFFFF9C;
    data_operandB = 32'd7;
    @(negedge clock);
    reset_n  = 1'b1;
    ctrl_DIV = 1'b0;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    chk("rst_start_busy_later", {31'd0, busy}, 32'd0);
    chk("rst_start_sign", {31'd0, dividend_sign}, 32'd0);
    run_vec(vecs[1], 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
